pwl_spi_host: RTL
=================

# pwl_spi_host

SPI bus master that issues register writes and reads to the TinyQV peripheral harness hosting the PWL synth. It takes one request at a time (address, write flag, 32-bit data), serialises it as a 40-bit mode-0 SPI frame onto the harness SPI pins, and returns read data. It lets a bench, an FPGA wrapper or a sequencer program channel period, amplitude, PWM offset, slopes, sweeps and mode registers without a CPU.

## Interface
Parameters:
- CLK_DIV, default 2: SCK half-period in clk cycles; legal range 1..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block idle, request accepted when valid & ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  6  peripheral register address
- req_wdata  in  32  write data (ignored for reads)
- rsp_valid  out  1  one-cycle pulse, transaction complete
- rsp_rdata  out  32  read data; 0 after a write
- spi_cs_n  out  1  chip select, active-low
- spi_sck  out  1  serial clock, idle low
- spi_mosi  out  1  serial data to harness
- spi_miso  in  1  serial data from harness

One clock; reset is asynchronous and active-low.

## Operation
- Frame: 40 bits, MSB first: cmd byte {req_write, 1'b0, req_addr[5:0]}, then 32 data bits (req_wdata for writes, 0 driven for reads).
- Request fields latched into a 40-bit shift register on accept; inputs may change afterwards.
- Mode 0: MOSI changes only while SCK low; MISO sampled on the last clk cycle of each SCK high phase.
- States: IDLE -> SHIFT -> HOLD -> GAP -> IDLE.
  - IDLE: req_ready=1, cs_n=1, sck=0, mosi=0.
  - SHIFT: cs_n=0; per bit, CLK_DIV cycles sck=0 then CLK_DIV cycles sck=1; 40 bits; bit counter 6 bits, divider counter 8 bits.
  - HOLD: sck=0, cs_n=0, mosi=0 for CLK_DIV cycles after the last falling edge.
  - GAP: cs_n=1 for CLK_DIV cycles, req_ready=0.
- MISO bits shift into a 32-bit receive register; only the last 32 sampled bits (data phase) are kept. On completion rsp_rdata <= received word if read, 0 if write.
- req_valid while req_ready=0 is ignored; no queuing.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, spi_cs_n=1, spi_sck=0, spi_mosi=0; state IDLE, counters 0.
- Accept at edge T: cycle T+1 cs_n=0, sck=0, mosi=cmd[7].
- cs_n low exactly 81*CLK_DIV cycles (80 for shifting, CLK_DIV for HOLD).
- rsp_valid high for exactly one cycle, the first cycle cs_n=1; rsp_rdata valid from that cycle and held until the next completion.
- req_ready returns high CLK_DIV cycles after cs_n rises. With req_valid held, cs_n is high for CLK_DIV+1 cycles between frames.
- Request-to-response latency: 81*CLK_DIV+1 cycles after the accepting edge.
- CLK_DIV=1: sck toggles every cycle, 81 cycles cs_n low; no phase may be shortened to 0.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronously). No rsp_valid for the aborted frame. The harness sees cs_n rise, which aborts its transaction.
- MISO is used directly, without a synchroniser. The harness is on the same clock.

## Test plan
- Write, CLK_DIV=2, addr 0x05, data 0x12345678 -> MOSI decodes to 0x85 then 0x12345678; cs_n low 162 cycles; rsp_valid once; rsp_rdata=0.
- Read, addr 0x21, MISO model returns 0xDEADBEEF in the data phase -> MOSI cmd 0x21 then 32 zeros; rsp_rdata=0xDEADBEEF on the rsp_valid cycle.
- Back-to-back, req_valid held high for two writes -> exactly two frames; cs_n high 3 cycles between them; req_ready low throughout each frame.
- CLK_DIV=1 read of 0xA5A5A5A5 -> sck period 2 cycles; cs_n low 81 cycles; data correct; latency 82 cycles.
- rst_n pulsed low at bit 20 of a write -> cs_n=1 and sck=0 in the same cycle; no rsp_valid; req_ready=1 after release; the next request completes normally.
- Through the harness: write the channel-0 period register with 0x0ABC -> harness internal period0 reads 0x0ABC after rsp_valid.

Source files
------------

// File: rtl/pwl_spi_host.sv
// pwl_spi_host
//   SPI mode-0 bus master for register access into the TinyQV peripheral
//   harness that hosts the PWL synth. Each accepted request becomes a 40-bit
//   frame, MSB first: command byte {write, 1'b0, addr[5:0]} and then 32 data
//   bits (write data, or zeros for a read). The read word is taken from the
//   last 32 MISO bits of the frame.
//
// Ports
//   clk, rst_n              system clock, asynchronous active-low reset
//   req_valid / req_ready   request handshake
//   req_write               1 = write, 0 = read
//   req_addr[5:0]           peripheral register address
//   req_wdata[31:0]         write data (ignored for reads)
//   rsp_valid               one-cycle pulse on the first cycle after cs_n rises
//   rsp_rdata[31:0]         read word, 0 after a write; held until next completion
//   spi_cs_n, spi_sck,      harness SPI pins; sck idles low
//   spi_mosi, spi_miso
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE; req_valid at any
// other time is ignored and nothing is queued. Request fields are captured
// on the accepting edge, so the requester may change them afterwards.
//
// Parameter CLK_DIV (1..255) is the SCK half-period in clk cycles.

module pwl_spi_host #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [5:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [5:0] BIT_LAST = 6'd39;

    state_t      state_q, state_d;
    logic [7:0]  div_q;      // clk cycles spent in the current phase
    logic [5:0]  bit_q;      // frame bit currently on the wire
    logic        sck_hi_q;   // 0 = low half of the bit, 1 = high half
    logic [39:0] tx_q;       // outgoing frame, bit 39 drives MOSI
    logic [31:0] rx_q;       // last 32 MISO samples
    logic        wr_q;       // latched write flag of the frame in flight
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        div_done;

    assign div_done = (div_q == DIV_LAST);

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid) state_d = S_SHIFT;
            S_SHIFT: if (div_done && sck_hi_q && (bit_q == BIT_LAST)) state_d = S_HOLD;
            S_HOLD:  if (div_done) state_d = S_GAP;
            S_GAP:   if (div_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pin outputs decode straight from registered state, so the asynchronous
    // reset drives every pin to its idle value immediately.
    always_comb begin
        req_ready = (state_q == S_IDLE);
        spi_cs_n  = !((state_q == S_SHIFT) || (state_q == S_HOLD));
        spi_sck   = (state_q == S_SHIFT) && sck_hi_q;
        spi_mosi  = (state_q == S_SHIFT) && tx_q[39];
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            sck_hi_q    <= 1'b0;
            tx_q        <= '0;
            rx_q        <= '0;
            wr_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    div_q    <= '0;
                    bit_q    <= '0;
                    sck_hi_q <= 1'b0;
                    if (req_valid) begin
                        tx_q <= {req_write, 1'b0, req_addr,
                                 (req_write ? req_wdata : 32'h0)};
                        wr_q <= req_write;
                    end
                end
                S_SHIFT: begin
                    if (div_done) begin
                        div_q <= '0;
                        if (sck_hi_q) begin
                            // End of the high phase: sample MISO, then the
                            // falling edge moves the next bit onto MOSI.
                            sck_hi_q <= 1'b0;
                            rx_q     <= {rx_q[30:0], spi_miso};
                            tx_q     <= {tx_q[38:0], 1'b0};
                            bit_q    <= bit_q + 6'd1;
                        end else begin
                            sck_hi_q <= 1'b1;
                        end
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                S_HOLD: begin
                    div_q <= div_done ? 8'd0 : div_q + 8'd1;
                    if (div_done) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= wr_q ? 32'h0 : rx_q;
                    end
                end
                S_GAP: begin
                    div_q <= div_done ? 8'd0 : div_q + 8'd1;
                end
                default: div_q <= '0;
            endcase
        end
    end

endmodule
